// File: rtl/intra_pkg.sv
// rtl/intra_pkg.sv - shared constants for the intra_loop macroblock context unit.
// Frame geometry defaults, Intra16x16 mode bit indices and fixed 4x4 neighbour masks.
package intra_pkg;

    localparam int MB_W_DEF = 120;
    localparam int MB_H_DEF = 68;

    localparam int I16_V     = 0;
    localparam int I16_H     = 1;
    localparam int I16_DC    = 2;
    localparam int I16_PLANE = 3;

    // Neighbours that lie inside the macroblock, bit = by*4+bx.
    // Left: every block with bx>0. Top: every block with by>0.
    localparam logic [15:0] LEFT4_INNER = 16'hEEEE;
    localparam logic [15:0] TOP4_INNER  = 16'hFFF0;

    // Inner top-right: rows 1..3 drop bx==3, and bx==1 on odd rows, because
    // that neighbour is coded later in the 8x8/4x4 zig-zag order.
    localparam logic [15:0] TR4_INNER   = 16'h5750;

    function automatic logic [15:0] tr4_row0(input logic avail_top, input logic avail_topright);
        return {12'h000, avail_topright, {3{avail_top}}};
    endfunction

endpackage

// File: rtl/intra_avail4x4.sv
// rtl/intra_avail4x4.sv - per-4x4-block neighbour masks from macroblock availability.
module intra_avail4x4
    import intra_pkg::*;
(
    input  logic        avail_left,
    input  logic        avail_top,
    input  logic        avail_topright,
    output logic [15:0] left4_mask,
    output logic [15:0] top4_mask,
    output logic [15:0] tr4_mask
);

    assign left4_mask = avail_left ? 16'hFFFF : LEFT4_INNER;
    assign top4_mask  = avail_top  ? 16'hFFFF : TOP4_INNER;
    assign tr4_mask   = TR4_INNER | tr4_row0(avail_top, avail_topright);

endmodule

// File: rtl/intra_loop.sv
// rtl/intra_loop.sv - registered per-macroblock intra context (position, availability, masks).
// Optional macro INTRA_LOOP_PLANE_EN enables the Intra16x16 plane mode bit.
module intra_loop
    import intra_pkg::*;
#(
    parameter int MB_W = MB_W_DEF,
    parameter int MB_H = MB_H_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [12:0] mbnumber,
    output logic        mb_valid,
    output logic [6:0]  mb_x,
    output logic [6:0]  mb_y,
    output logic        first_mb,
    output logic        last_in_row,
    output logic        last_mb,
    output logic        avail_left,
    output logic        avail_top,
    output logic        avail_topright,
    output logic        avail_topleft,
    output logic [3:0]  i16_mode_mask,
    output logic [15:0] left4_mask,
    output logic [15:0] top4_mask,
    output logic [15:0] tr4_mask
);

    localparam logic [12:0] W13   = 13'(MB_W);
    localparam logic [12:0] N13   = 13'(MB_W * MB_H);
    localparam logic [6:0]  XLAST = 7'(MB_W - 1);

    logic        n_valid;
    logic [6:0]  n_x;
    logic [6:0]  n_y;
    logic        n_left;
    logic        n_top;
    logic        n_tr;
    logic        n_tl;
    logic        n_plane;
    logic [3:0]  n_mode;
    logic [15:0] m_left4;
    logic [15:0] m_top4;
    logic [15:0] m_tr4;

    // Constant divisor: synthesis reduces these to a multiply/shift network.
    always_comb begin
        n_valid = mbnumber < N13;
        n_x     = 7'd0;
        n_y     = 7'd0;
        if (n_valid) begin
            n_x = 7'(mbnumber % W13);
            n_y = 7'(mbnumber / W13);
        end
        n_left = n_valid && (n_x != 7'd0);
        n_top  = n_valid && (n_y != 7'd0);
        n_tr   = n_top && (n_x != XLAST);
        n_tl   = n_top && n_left;
`ifdef INTRA_LOOP_PLANE_EN
        n_plane = n_left && n_top && n_tl;
`else
        n_plane = 1'b0;
`endif
        n_mode            = 4'd0;
        n_mode[I16_V]     = n_top;
        n_mode[I16_H]     = n_left;
        n_mode[I16_DC]    = n_valid;
        n_mode[I16_PLANE] = n_plane;
    end

    intra_avail4x4 u_avail4x4 (
        .avail_left     (n_left),
        .avail_top      (n_top),
        .avail_topright (n_tr),
        .left4_mask     (m_left4),
        .top4_mask      (m_top4),
        .tr4_mask       (m_tr4)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mb_valid       <= 1'b0;
            mb_x           <= 7'd0;
            mb_y           <= 7'd0;
            first_mb       <= 1'b0;
            last_in_row    <= 1'b0;
            last_mb        <= 1'b0;
            avail_left     <= 1'b0;
            avail_top      <= 1'b0;
            avail_topright <= 1'b0;
            avail_topleft  <= 1'b0;
            i16_mode_mask  <= 4'd0;
            left4_mask     <= 16'd0;
            top4_mask      <= 16'd0;
            tr4_mask       <= 16'd0;
        end else if (enable) begin
            mb_valid       <= n_valid;
            mb_x           <= n_x;
            mb_y           <= n_y;
            first_mb       <= n_valid && (mbnumber == 13'd0);
            last_in_row    <= n_valid && (n_x == XLAST);
            last_mb        <= mbnumber == (N13 - 13'd1);
            avail_left     <= n_left;
            avail_top      <= n_top;
            avail_topright <= n_tr;
            avail_topleft  <= n_tl;
            i16_mode_mask  <= n_mode;
            left4_mask     <= n_valid ? m_left4 : 16'd0;
            top4_mask      <= n_valid ? m_top4  : 16'd0;
            tr4_mask       <= n_valid ? m_tr4   : 16'd0;
        end
    end

endmodule

// File: tb/tb_intra_loop.sv
// tb/tb_intra_loop.sv - table-driven self-checking bench for intra_loop.
module tb_intra_loop;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [12:0] mbnumber;
    logic        mb_valid;
    logic [6:0]  mb_x;
    logic [6:0]  mb_y;
    logic        first_mb;
    logic        last_in_row;
    logic        last_mb;
    logic        avail_left;
    logic        avail_top;
    logic        avail_topright;
    logic        avail_topleft;
    logic [3:0]  i16_mode_mask;
    logic [15:0] left4_mask;
    logic [15:0] top4_mask;
    logic [15:0] tr4_mask;

    int tests = 0;
    int fails = 0;

    intra_loop dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .mbnumber       (mbnumber),
        .mb_valid       (mb_valid),
        .mb_x           (mb_x),
        .mb_y           (mb_y),
        .first_mb       (first_mb),
        .last_in_row    (last_in_row),
        .last_mb        (last_mb),
        .avail_left     (avail_left),
        .avail_top      (avail_top),
        .avail_topright (avail_topright),
        .avail_topleft  (avail_topleft),
        .i16_mode_mask  (i16_mode_mask),
        .left4_mask     (left4_mask),
        .top4_mask      (top4_mask),
        .tr4_mask       (tr4_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {valid, first, last_in_row, last_mb, left, top, topright, topleft}
    typedef struct {
        logic [12:0] mbn;
        logic [6:0]  x;
        logic [6:0]  y;
        logic [7:0]  flags;
        logic [3:0]  mode;
        logic [15:0] left4;
        logic [15:0] top4;
        logic [15:0] tr4;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] flags_now();
        return {mb_valid, first_mb, last_in_row, last_mb,
                avail_left, avail_top, avail_topright, avail_topleft};
    endfunction

    function automatic logic any_out();
        return |{mb_valid, mb_x, mb_y, first_mb, last_in_row, last_mb,
                 avail_left, avail_top, avail_topright, avail_topleft,
                 i16_mode_mask, left4_mask, top4_mask, tr4_mask};
    endfunction

    initial begin
        logic [3:0] exp_mode;
        int cap;

        vecs[0] = '{13'h1FFF, 7'd0,   7'd0,  8'b0000_0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[1] = '{13'd0,    7'd0,   7'd0,  8'b1100_0000, 4'b0100, 16'hEEEE, 16'hFFF0, 16'h5750};
        vecs[2] = '{13'd119,  7'd119, 7'd0,  8'b1010_1000, 4'b0110, 16'hFFFF, 16'hFFF0, 16'h5750};
        vecs[3] = '{13'd121,  7'd1,   7'd1,  8'b1000_1111, 4'b1111, 16'hFFFF, 16'hFFFF, 16'h575F};
        vecs[4] = '{13'd239,  7'd119, 7'd1,  8'b1010_1101, 4'b1111, 16'hFFFF, 16'hFFFF, 16'h5757};
        vecs[5] = '{13'd120,  7'd0,   7'd1,  8'b1000_0110, 4'b0101, 16'hEEEE, 16'hFFFF, 16'h575F};
        vecs[6] = '{13'd8159, 7'd119, 7'd67, 8'b1011_1101, 4'b1111, 16'hFFFF, 16'hFFFF, 16'h5757};
        vecs[7] = '{13'd8160, 7'd0,   7'd0,  8'b0000_0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[8] = '{13'd8040, 7'd0,   7'd67, 8'b1000_0110, 4'b0101, 16'hEEEE, 16'hFFFF, 16'h575F};
        vecs[9] = '{13'd5,    7'd5,   7'd0,  8'b1000_1000, 4'b0110, 16'hFFFF, 16'hFFF0, 16'h5750};

        reset    = 1'b0;
        enable   = 1'b0;
        mbnumber = 13'd0;
        #1;
        chk("reset_outputs", 64'(any_out()), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mbnumber = vecs[i].mbn;
            enable   = 1'b1;
            @(posedge clk);
            #1;
            exp_mode = vecs[i].mode;
`ifndef INTRA_LOOP_PLANE_EN
            exp_mode[3] = 1'b0;
`endif
            chk($sformatf("v%0d_mb_x", i),  64'(mb_x),          64'(vecs[i].x));
            chk($sformatf("v%0d_mb_y", i),  64'(mb_y),          64'(vecs[i].y));
            chk($sformatf("v%0d_flags", i), 64'(flags_now()),   64'(vecs[i].flags));
            chk($sformatf("v%0d_mode", i),  64'(i16_mode_mask), 64'(exp_mode));
            chk($sformatf("v%0d_left4", i), 64'(left4_mask),    64'(vecs[i].left4));
            chk($sformatf("v%0d_top4", i),  64'(top4_mask),     64'(vecs[i].top4));
            chk($sformatf("v%0d_tr4", i),   64'(tr4_mask),      64'(vecs[i].tr4));
        end

        // Streaming: index changes every falling edge, enable low for three cycles.
        cap = 5;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            mbnumber = 13'(i);
            enable   = !(i >= 4 && i <= 6);
            if (enable) cap = i;
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d_mb_x", i),  64'(mb_x),     64'(cap % 120));
            chk($sformatf("stream%0d_first", i), 64'(first_mb), 64'(cap == 0));
            chk($sformatf("stream%0d_left", i),  64'(avail_left), 64'(cap != 0));
        end

        // Reset mid-stream clears outputs before any clock edge.
        @(negedge clk);
        mbnumber = 13'd121;
        enable   = 1'b1;
        @(posedge clk);
        #2;
        chk("pre_reset_valid", 64'(mb_valid), 64'd1);
        reset = 1'b0;
        #1;
        chk("async_reset_clear", 64'(any_out()), 64'd0);
        @(negedge clk);
        reset    = 1'b1;
        mbnumber = 13'd239;
        @(posedge clk);
        #1;
        chk("post_reset_mb_x", 64'(mb_x), 64'd119);
        chk("post_reset_mb_y", 64'(mb_y), 64'd1);
        chk("post_reset_tr4",  64'(tr4_mask), 64'h5757);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
